// File: rtl/ofmap_out_ctrl_pkg.sv
// rtl/ofmap_out_ctrl_pkg.sv - shared mode and state encodings for the ofmap writeback sequencer
package ofmap_out_ctrl_pkg;

  // Source-select encodings; these double as the ofmap mux select values.
  typedef enum logic [1:0] {
    OFM_RELU    = 2'd0,
    OFM_ACCU    = 2'd1,
    OFM_POOL    = 2'd2,
    OFM_ILLEGAL = 2'd3
  } ofm_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STREAM    = 3'd1,
    ST_POOL_ACC  = 3'd2,
    ST_POOL_EMIT = 3'd3,
    ST_DONE      = 3'd4
  } ofm_state_e;

endpackage

// File: rtl/ofmap_addr_gen.sv
// rtl/ofmap_addr_gen.sv - base-loaded write address counter with remaining-word tracking
module ofmap_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;

  // Load on job accept; advance on every accepted write. Address wraps silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (load_i) begin
      addr_q      <= base_i;
      remaining_q <= len_i;
    end else if (step_i) begin
      addr_q      <= addr_q + ADDR_W'(1);
      remaining_q <= remaining_q - LEN_W'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remaining_q == LEN_W'(1));

endmodule

// File: rtl/ofmap_out_ctrl.sv
// rtl/ofmap_out_ctrl.sv - ofmap writeback sequencer: mux select, pool strobes, buffer writes
module ofmap_out_ctrl
  import ofmap_out_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int LEN_W    = 12,
  parameter int POOL_WIN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [1:0]        mux_sel_o,
  output logic              pool_clr_o,
  output logic              pool_en_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  input  logic              wr_ready_i
);

  localparam int WIN_W = $clog2(POOL_WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL_WIN - 1);

  ofm_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [1:0]       mux_sel_q, mux_sel_d;
  logic             err_q, err_d;
  logic             load, step, last;

  ofmap_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .base_i (cfg_base_i),
    .len_i  (cfg_len_i),
    .step_i (step),
    .addr_o (wr_addr_o),
    .last_o (last)
  );

  // State, window counter, held mux select and the registered error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      mux_sel_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      mux_sel_q <= mux_sel_d;
      err_q     <= err_d;
    end
  end

  // Next-state and handshake decode; stream path is a zero-latency pass-through of wr_ready.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    mux_sel_d  = mux_sel_q;
    err_d      = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    in_ready_o = 1'b0;
    wr_en_o    = 1'b0;
    pool_en_o  = 1'b0;
    pool_clr_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_mode_i == OFM_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            load      = 1'b1;
            mux_sel_d = cfg_mode_i;
            win_cnt_d = '0;
            if (cfg_len_i == '0)              state_d = ST_DONE;
            else if (cfg_mode_i == OFM_POOL)  state_d = ST_POOL_ACC;
            else                              state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        in_ready_o = wr_ready_i;
        wr_en_o    = in_valid_i & wr_ready_i;
        if (wr_en_o) begin
          step = 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      ST_POOL_ACC: begin
        in_ready_o = 1'b1;
        pool_en_o  = in_valid_i;
        pool_clr_o = in_valid_i & (win_cnt_q == '0);
        if (in_valid_i) begin
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            state_d   = ST_POOL_EMIT;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
      end
      ST_POOL_EMIT: begin
        wr_en_o = 1'b1;
        if (wr_ready_i) begin
          step    = 1'b1;
          state_d = last ? ST_DONE : ST_POOL_ACC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = err_q;
  assign mux_sel_o = mux_sel_q;

endmodule

// File: tb/tb_ofmap_out_ctrl.sv
// tb/tb_ofmap_out_ctrl.sv - self-checking bench for ofmap_out_ctrl with randomized handshakes
module tb_ofmap_out_ctrl;

  localparam int ADDR_W   = 12;
  localparam int LEN_W    = 12;
  localparam int POOL_WIN = 4;

  logic              clk, rst, start, in_valid, wr_ready;
  logic [1:0]        cfg_mode;
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W-1:0] cfg_base;
  logic              busy, done, err, in_ready, pool_clr, pool_en, wr_en;
  logic [1:0]        mux_sel;
  logic [ADDR_W-1:0] wr_addr;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int exp_addr  = 0;
  int last_mode = 0;
  int hit, quiet;

  ofmap_out_ctrl #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .POOL_WIN (POOL_WIN)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .cfg_mode_i (cfg_mode),
    .cfg_len_i  (cfg_len),
    .cfg_base_i (cfg_base),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .mux_sel_o  (mux_sel),
    .pool_clr_o (pool_clr),
    .pool_en_o  (pool_en),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_ready_i (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One job: start pulse, random in_valid/wr_ready, optional stray starts while busy.
  // Expectations come from the job description: len writes at base+k, beat counts, one done.
  task automatic run_job(input logic [1:0] mode, input int len, input int base,
                         input int vpct, input int rpct, input bit noise);
    int writes = 0, beats = 0, pen = 0, pclr = 0, dones = 0, errs = 0, busy_cnt = 0;
    int bad_addr = 0, bad_proto = 0, bad_mux = 0;
    int done_cyc = -100, err_cyc = -100, first_wr = -100, last_wr = -100, busy_after = -1;
    int limit;
    bit legal, pool, mid;
    logic [ADDR_W-1:0] addrs[$];
    legal = (mode != 2'd3);
    pool  = (mode == 2'd2);
    limit = legal ? 400 : 4;
    mid   = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cfg_mode = mode; cfg_len = LEN_W'(len); cfg_base = ADDR_W'(base);
    in_valid = 1'b0; wr_ready = 1'b0;
    for (int cyc = 0; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (err) begin errs++; err_cyc = cyc; end
      if (done) begin dones++; done_cyc = cyc; end
      if (legal && busy && mux_sel !== mode) bad_mux++;
      if (in_ready && (!busy || done || (pool && wr_en))) bad_proto++;
      if (wr_en && (!busy || done)) bad_proto++;
      if (!pool && wr_en && !(in_valid && wr_ready)) bad_proto++;
      pen  += int'(pool_en);
      pclr += int'(pool_clr);
      if (in_valid && in_ready) begin
        if (pool && (pool_clr !== (beats % POOL_WIN == 0) || !pool_en)) bad_proto++;
        beats++;
      end
      if (wr_en && wr_ready) begin
        addrs.push_back(wr_addr);
        writes++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (pool && beats != POOL_WIN * writes) bad_proto++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = int'(busy);
        break;
      end
      mid = busy && !done;
      @(posedge clk); #1;
      start    = noise && mid && ($urandom_range(0, 1) == 1);
      cfg_mode = 2'($urandom);
      cfg_len  = LEN_W'($urandom);
      cfg_base = ADDR_W'($urandom);
      in_valid = ($urandom_range(0, 99) < vpct);
      wr_ready = ($urandom_range(0, 99) < rpct);
    end
    start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    if (legal) begin
      for (int k = 0; k < addrs.size(); k++)
        if (addrs[k] !== ADDR_W'(base + k)) bad_addr++;
      chk("write_count", writes, len);
      chk("addr_seq", bad_addr, 0);
      chk("done_count", dones, 1);
      chk("done_timing", done_cyc, (len == 0) ? 1 : last_wr + 1);
      chk("busy_after_done", busy_after, 0);
      chk("err_absent", errs, 0);
      chk("mux_held", bad_mux, 0);
      chk("beats", beats, pool ? len * POOL_WIN : len);
      chk("pool_en_count", pen, pool ? len * POOL_WIN : 0);
      chk("pool_clr_count", pclr, pool ? len : 0);
      chk("protocol", bad_proto, 0);
      if (vpct == 100 && rpct == 100 && !pool && len > 0)
        chk("full_rate", first_wr * 1000 + last_wr, 1000 + len);
      exp_addr  = (base + len) % (1 << ADDR_W);
      last_mode = int'(mode);
    end else begin
      chk("err_pulse", errs * 1000 + err_cyc, 1001);
      chk("illegal_busy", busy_cnt, 0);
      chk("illegal_writes", writes, 0);
    end
    chk("wr_addr_final", int'(wr_addr), exp_addr);
    chk("mux_final", int'(mux_sel), last_mode);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    cfg_mode = '0; cfg_len = '0; cfg_base = '0;
    @(posedge clk); #1;
    chk("reset_outputs", int'({busy, done, err, in_ready, mux_sel, pool_clr, pool_en, wr_en, wr_addr}), 0);
    @(negedge clk); rst = 1'b0;

    run_job(2'd0, 3, 'h010, 100, 100, 1'b0);
    run_job(2'd1, 2, 'h3A0, 100, 50, 1'b0);
    run_job(2'd2, 2, 'h040, 90, 60, 1'b0);
    run_job(2'd3, 5, 'h777, 100, 100, 1'b0);
    run_job(2'd1, 0, 'h055, 100, 100, 1'b0);
    run_job(2'd0, 3, 'hFFE, 80, 80, 1'b1);
    run_job(2'd2, 3, 'hFFF, 100, 70, 1'b1);
    for (int i = 0; i < 6; i++)
      run_job(2'($urandom_range(0, 2)), int'($urandom_range(1, 6)), int'($urandom_range(0, 4095)),
              int'($urandom_range(50, 100)), int'($urandom_range(50, 100)), 1'b1);

    // Abort a pool job while it is stalled in its emit phase.
    @(posedge clk); #1;
    start = 1'b1; cfg_mode = 2'd2; cfg_len = LEN_W'(3); cfg_base = ADDR_W'('h123);
    in_valid = 1'b1; wr_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 30 && hit == 0; i++) begin
      @(negedge clk);
      hit = int'(wr_en);
    end
    chk("reach_pool_emit", hit, 1);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("reset_midjob_outputs", int'({busy, done, err, in_ready, mux_sel, pool_clr, pool_en, wr_en, wr_addr}), 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      quiet += int'(done) + int'(busy);
    end
    chk("no_done_after_abort", quiet, 0);
    exp_addr = 0; last_mode = 0;
    run_job(2'd0, 4, 'h200, 100, 100, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
